// File: rtl/io_irq_sched.sv
// io_irq_sched: IRQ scheduler between the peripheral enable masks and the core.
// Rising edges of the masked IRQ lines are latched into a pending register.
// One winner is presented to the core with a req/ack/eoi handshake.
// Register window (word access only):
//   base+0 PEND : read pending, write-1-clear
//   base+2 STAT : read {state[9:8], vec[CVecLen-1:0]}, write-1-set pending
// Build option: define IRQ_SCHED_RR_EN for round-robin arbitration.
// Without it, the lowest set index wins.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for any pending bit; latches the winner into vec
// REQ   | AIrqReq=1, waiting for AIrqAck; ack clears pending[vec]
// SERV  | core is servicing vec; waiting for AIrqEoi

module io_irq_sched #(
    parameter logic [15:0] CAddrBase = 16'h0000,
    parameter int          CIrqCnt   = 16,
    parameter int          CVecLen   = 4
) (
    input  logic               AClkH,
    input  logic               AResetHN,
    input  logic               AClkHEn,
    input  logic [15:0]        AIoAddr,
    output logic [63:0]        AIoMiso,
    input  logic [63:0]        AIoMosi,
    input  logic [3:0]         AIoWrSize,
    input  logic [3:0]         AIoRdSize,
    output logic               AIoAddrAck,
    output logic               AIoAddrErr,
    input  logic [CIrqCnt-1:0] AIrqI,
    output logic               AIrqReq,
    output logic [CVecLen-1:0] AIrqVec,
    input  logic               AIrqAck,
    input  logic               AIrqEoi
);

    localparam logic [1:0] st_idle = 2'd0;
    localparam logic [1:0] st_req  = 2'd1;
    localparam logic [1:0] st_serv = 2'd2;

    // Size strobe is one-hot {qword, dword, word, byte}; only word is legal here.
    localparam logic [3:0] size_word = 4'b0010;

    logic [CIrqCnt-1:0] pend;
    logic [CIrqCnt-1:0] prev;
    logic [CIrqCnt-1:0] pend_nxt;
    logic [CIrqCnt-1:0] set_hw;
    logic [CIrqCnt-1:0] w1c;
    logic [CIrqCnt-1:0] sw_set;
    logic [CIrqCnt-1:0] ack_clr;
    logic [1:0]         state;
    logic [CVecLen-1:0] vec;
    logic [CVecLen-1:0] win;
    logic               found;

    logic               sel_pend;
    logic               sel_stat;
    logic               sel;
    logic               any_size;
    logic               legal;
    logic               wr_ok;
    logic               rd_ok;
    logic [63:0]        pend_word;
    logic [63:0]        stat_word;

`ifdef IRQ_SCHED_RR_EN
    logic [CVecLen-1:0] ptr;
`endif

    // Upper write-data bits beyond the IRQ count carry no register bits.
    logic unused_mosi;
    assign unused_mosi = ^AIoMosi;

    // Address decode and access legality.
    always_comb begin
        sel_pend   = (AIoAddr == CAddrBase);
        sel_stat   = (AIoAddr == (CAddrBase + 16'd2));
        sel        = sel_pend | sel_stat;
        any_size   = |{AIoWrSize, AIoRdSize};
        legal      = any_size &&
                     ((AIoWrSize == 4'b0000) || (AIoWrSize == size_word)) &&
                     ((AIoRdSize == 4'b0000) || (AIoRdSize == size_word));
        AIoAddrAck = sel & legal;
        AIoAddrErr = sel & any_size & ~legal;
        wr_ok      = sel & legal & (AIoWrSize == size_word);
        rd_ok      = sel & legal & (AIoRdSize == size_word);
    end

    // Read mux; unselected or illegal accesses read zero.
    always_comb begin
        pend_word                = '0;
        pend_word[CIrqCnt-1:0]   = pend;
        stat_word                = '0;
        stat_word[9:8]           = state;
        stat_word[CVecLen-1:0]   = vec;
        AIoMiso                  = '0;
        if (rd_ok) begin
            AIoMiso = sel_pend ? pend_word : stat_word;
        end
    end

    // Pending next-state: sets beat software clears, the ack clear beats everything.
    always_comb begin
        set_hw  = AIrqI & ~prev;
        w1c     = (wr_ok && sel_pend) ? AIoMosi[CIrqCnt-1:0] : '0;
        sw_set  = (wr_ok && sel_stat) ? AIoMosi[CIrqCnt-1:0] : '0;
        ack_clr = '0;
        for (int i = 0; i < CIrqCnt; i++) begin
            ack_clr[i] = (state == st_req) && AIrqAck && (vec == i[CVecLen-1:0]);
        end
        pend_nxt = ((pend & ~w1c) | set_hw | sw_set) & ~ack_clr;
    end

    // Winner selection over the current pending register.
`ifdef IRQ_SCHED_RR_EN
    always_comb begin
        int best_d;
        int d;
        found  = 1'b0;
        win    = '0;
        best_d = CIrqCnt;
        d      = 0;
        for (int j = 0; j < CIrqCnt; j++) begin
            // Distance from the slot after the last-served pointer, modulo CIrqCnt.
            d = j - int'(ptr) - 1;
            if (d < 0) begin
                d = d + CIrqCnt;
            end
            if (pend[j] && (d < best_d)) begin
                best_d = d;
                found  = 1'b1;
                win    = j[CVecLen-1:0];
            end
        end
    end
`else
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int j = 0; j < CIrqCnt; j++) begin
            if (pend[j] && !found) begin
                found = 1'b1;
                win   = j[CVecLen-1:0];
            end
        end
    end
`endif

    // Pending and edge-sample registers.
    always_ff @(posedge AClkH or negedge AResetHN) begin
        if (!AResetHN) begin
            pend <= '0;
            prev <= '0;
        end else if (AClkHEn) begin
            pend <= pend_nxt;
            prev <= AIrqI;
        end
    end

    // Handshake FSM; the winner stays fixed from IDLE until the next IDLE.
    always_ff @(posedge AClkH or negedge AResetHN) begin
        if (!AResetHN) begin
            state <= st_idle;
            vec   <= '0;
`ifdef IRQ_SCHED_RR_EN
            ptr   <= '0;
`endif
        end else if (AClkHEn) begin
            case (state)
                st_idle: begin
                    if (found) begin
                        vec   <= win;
                        state <= st_req;
                    end
                end
                st_req: begin
                    if (AIrqAck) begin
                        state <= st_serv;
`ifdef IRQ_SCHED_RR_EN
                        ptr   <= vec;
`endif
                    end
                end
                st_serv: begin
                    if (AIrqEoi) begin
                        state <= st_idle;
                    end
                end
                default: state <= st_idle;
            endcase
        end
    end

    assign AIrqReq = (state == st_req);
    assign AIrqVec = vec;

endmodule

// File: tb/tb_io_irq_sched.sv
// Directed bench for io_irq_sched: handshake, priority, register window,
// clock enable and asynchronous reset behaviour.
module tb_io_irq_sched;

    localparam logic [15:0] BASE = 16'h0000;
    localparam logic [3:0]  WORD = 4'b0010;
`ifdef IRQ_SCHED_RR_EN
    localparam int FIRST  = 9;
    localparam int SECOND = 3;
`else
    localparam int FIRST  = 3;
    localparam int SECOND = 9;
`endif

    logic        AClkH;
    logic        AResetHN;
    logic        AClkHEn;
    logic [15:0] AIoAddr;
    logic [63:0] AIoMiso;
    logic [63:0] AIoMosi;
    logic [3:0]  AIoWrSize;
    logic [3:0]  AIoRdSize;
    logic        AIoAddrAck;
    logic        AIoAddrErr;
    logic [15:0] AIrqI;
    logic        AIrqReq;
    logic [3:0]  AIrqVec;
    logic        AIrqAck;
    logic        AIrqEoi;

    int checks   = 0;
    int failures = 0;

    io_irq_sched #(.CAddrBase(BASE), .CIrqCnt(16), .CVecLen(4)) dut (
        .AClkH      (AClkH),
        .AResetHN   (AResetHN),
        .AClkHEn    (AClkHEn),
        .AIoAddr    (AIoAddr),
        .AIoMiso    (AIoMiso),
        .AIoMosi    (AIoMosi),
        .AIoWrSize  (AIoWrSize),
        .AIoRdSize  (AIoRdSize),
        .AIoAddrAck (AIoAddrAck),
        .AIoAddrErr (AIoAddrErr),
        .AIrqI      (AIrqI),
        .AIrqReq    (AIrqReq),
        .AIrqVec    (AIrqVec),
        .AIrqAck    (AIrqAck),
        .AIrqEoi    (AIrqEoi)
    );

    initial begin
        AClkH = 1'b0;
        forever #5 AClkH = ~AClkH;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge AClkH);
        #1;
    endtask

    task automatic io_wr(input logic [15:0] a, input logic [63:0] d, input logic [3:0] sz);
        AIoAddr   = a;
        AIoMosi   = d;
        AIoWrSize = sz;
        tick();
        AIoWrSize = 4'b0000;
        AIoMosi   = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] a, input logic [63:0] exp);
        AIoAddr   = a;
        AIoRdSize = WORD;
        #1;
        check(tag, AIoMiso, exp);
        AIoRdSize = 4'b0000;
    endtask

    task automatic pulse_ack();
        AIrqAck = 1'b1;
        tick();
        AIrqAck = 1'b0;
    endtask

    task automatic pulse_eoi();
        AIrqEoi = 1'b1;
        tick();
        AIrqEoi = 1'b0;
    endtask

    initial begin
        AResetHN  = 1'b0;
        AClkHEn   = 1'b1;
        AIoAddr   = '0;
        AIoMosi   = '0;
        AIoWrSize = '0;
        AIoRdSize = '0;
        AIrqI     = '0;
        AIrqAck   = 1'b0;
        AIrqEoi   = 1'b0;
        #22;
        check("rst_req", {63'd0, AIrqReq}, 64'd0);
        check("rst_vec", {60'd0, AIrqVec}, 64'd0);
        rd_chk("rst_pend", BASE, 64'h0);
        rd_chk("rst_stat", BASE + 16'd2, 64'h0);
        AResetHN = 1'b1;
        tick();

        // Single edge on IRQ 5: pending at n+1, request at n+2.
        AIrqI = 16'h0020;
        tick();
        rd_chk("a_pend", BASE, 64'h20);
        check("a_req_early", {63'd0, AIrqReq}, 64'd0);
        AIrqI = 16'h0000;
        tick();
        check("a_req", {63'd0, AIrqReq}, 64'd1);
        check("a_vec", {60'd0, AIrqVec}, 64'd5);
        rd_chk("a_stat_req", BASE + 16'd2, 64'h105);
        pulse_ack();
        rd_chk("a_pend_ack", BASE, 64'h0);
        check("a_req_serv", {63'd0, AIrqReq}, 64'd0);
        rd_chk("a_stat_serv", BASE + 16'd2, 64'h205);
        pulse_eoi();
        rd_chk("a_stat_idle", BASE + 16'd2, 64'h005);

        // Two simultaneous edges: priority order.
        AIrqI = 16'h0208;
        tick();
        rd_chk("b_pend", BASE, 64'h208);
        AIrqI = 16'h0000;
        tick();
        check("b_vec1", {60'd0, AIrqVec}, 64'(FIRST));
        pulse_ack();
        rd_chk("b_pend_ack", BASE, 64'h208 & ~(64'd1 << FIRST));
        pulse_eoi();
        tick();
        check("b_req2", {63'd0, AIrqReq}, 64'd1);
        check("b_vec2", {60'd0, AIrqVec}, 64'(SECOND));
        pulse_ack();
        pulse_eoi();
        rd_chk("b_pend_done", BASE, 64'h0);

        // Software trigger and software clear during SERV.
        io_wr(BASE + 16'd2, 64'h100, WORD);
        rd_chk("c_pend_sw", BASE, 64'h100);
        tick();
        check("c_req", {63'd0, AIrqReq}, 64'd1);
        check("c_vec", {60'd0, AIrqVec}, 64'd8);
        pulse_ack();
        io_wr(BASE + 16'd2, 64'h100, WORD);
        rd_chk("c_pend_serv", BASE, 64'h100);
        io_wr(BASE, 64'h100, WORD);
        rd_chk("c_pend_w1c", BASE, 64'h0);
        rd_chk("c_stat_serv", BASE + 16'd2, 64'h208);
        pulse_eoi();
        rd_chk("c_stat_idle", BASE + 16'd2, 64'h008);

        // Illegal size, out-of-window address.
        io_wr(BASE + 16'd2, 64'h2, WORD);
        AIoAddr   = BASE;
        AIoMosi   = 64'h2;
        AIoWrSize = 4'b0001;
        #1;
        check("d_err", {63'd0, AIoAddrErr}, 64'd1);
        check("d_ack", {63'd0, AIoAddrAck}, 64'd0);
        tick();
        AIoWrSize = 4'b0000;
        AIoMosi   = '0;
        rd_chk("d_pend_kept", BASE, 64'h2);
        AIoAddr   = BASE + 16'd4;
        AIoRdSize = WORD;
        #1;
        check("d_oob_ack", {63'd0, AIoAddrAck}, 64'd0);
        check("d_oob_err", {63'd0, AIoAddrErr}, 64'd0);
        check("d_oob_miso", AIoMiso, 64'd0);
        AIoAddr = BASE;
        #1;
        check("d_word_ack", {63'd0, AIoAddrAck}, 64'd1);
        AIoRdSize = 4'b0000;
        pulse_ack();
        pulse_eoi();

        // Same-cycle W1C and rising edge on bit 2; held level must not retrigger.
        AIrqI = 16'h0004;
        io_wr(BASE, 64'h4, WORD);
        rd_chk("e_pend_set_wins", BASE, 64'h4);
        tick();
        check("e_vec", {60'd0, AIrqVec}, 64'd2);
        pulse_ack();
        rd_chk("e_pend_level", BASE, 64'h0);
        pulse_eoi();
        tick();
        check("e_req_level", {63'd0, AIrqReq}, 64'd0);
        AIrqI = 16'h0000;
        tick();

        // Clock enable low: a pulse is not seen.
        AClkHEn = 1'b0;
        AIrqI   = 16'h0080;
        tick();
        AIrqI   = 16'h0000;
        tick();
        AClkHEn = 1'b1;
        tick();
        tick();
        rd_chk("f_pend_en", BASE, 64'h0);
        check("f_req_en", {63'd0, AIrqReq}, 64'd0);

        // Asynchronous reset while in REQ.
        io_wr(BASE + 16'd2, 64'h4, WORD);
        tick();
        check("g_req_pre", {63'd0, AIrqReq}, 64'd1);
        rd_chk("g_pend_pre", BASE, 64'h4);
        #1;
        AResetHN = 1'b0;
        #1;
        check("g_req_rst", {63'd0, AIrqReq}, 64'd0);
        rd_chk("g_pend_rst", BASE, 64'h0);
        rd_chk("g_stat_rst", BASE + 16'd2, 64'h0);
        #10;
        AResetHN = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_irq_sched.md
Name: io_irq_sched

Overview:
- Interrupt scheduler between the per-peripheral IRQ enable masks and the CPU core.
- Latches rising edges of already-masked IRQ lines into a pending register and picks one winner.
- Presents the winner to the core with a req/ack/eoi handshake.
- Exposes pending and status registers on the IO bus; software can clear or raise pending bits.

Parameters:
- CAddrBase, 16'h0000, IO base address of the register window
- CIrqCnt, 16, number of IRQ sources (1..16)
- CVecLen, 4, width of the vector output (must satisfy 2^CVecLen >= CIrqCnt)

Ports:
- AClkH  in  1  system clock
- AResetHN  in  1  asynchronous active-low reset
- AClkHEn  in  1  clock enable; no state changes when low
- AIoAddr  in  16  IO address
- AIoMiso  out  64  IO read data, zero when not selected
- AIoMosi  in  64  IO write data
- AIoWrSize  in  4  write size strobe
- AIoRdSize  in  4  read size strobe
- AIoAddrAck  out  1  address matched with legal size
- AIoAddrErr  out  1  address matched with illegal size
- AIrqI  in  CIrqCnt  masked IRQ lines
- AIrqReq  out  1  interrupt request to core
- AIrqVec  out  CVecLen  vector of the presented IRQ, valid while AIrqReq=1 and in SERV
- AIrqAck  in  1  core accepts the request
- AIrqEoi  in  1  core signals end of interrupt

Behaviour:
- Reset (asynchronous, active-low): pending=0, edge-sample register=0, state=IDLE, AIrqReq=0, AIrqVec=0. AIoMiso is combinational and reads 0 when not selected.
- All updates happen on the rising edge of AClkH, qualified by AClkHEn=1.
- Registers (word access only; byte/dword to a valid offset asserts AIoAddrErr, no side effect):
  - Base+0 PEND: read returns pending; write-1-clears.
  - Base+2 STAT: read returns {state[1:0] at bits 9:8, reserved 0, vec at bits CVecLen-1:0}; write-1-sets pending (software trigger).
- Edge detect: set_hw = AIrqI & ~prev. Pending update order: next = (pending & ~w1c) | set_hw | sw_set. A set on the same bit as a clear in the same cycle wins.
- Latency: AIrqI rises in cycle n → pending bit set at n+1 → AIrqReq=1 at n+2 (IDLE assumed). A level held high re-triggers only after it drops.
- FSM:
  - IDLE: if pending≠0, latch winner index into vec → REQ.
  - REQ: AIrqReq=1. On AIrqAck=1, clear pending[vec] → SERV. The ack-clear also wins over a simultaneous new edge on the same bit, which is lost; this is documented.
  - SERV: AIrqReq=0, vec held. On AIrqEoi=1 → IDLE.
  - No nesting. New edges during REQ/SERV only set pending. Winner is fixed once latched in REQ, even if software clears its pending bit; ack then clears an already-zero bit.
  - AIrqEoi in IDLE/REQ and AIrqAck outside REQ are ignored.
- Winner (default): lowest set index has highest priority.
- CIrqCnt<16: unused register bits read 0, writes ignored.

Optional Feature:
- IRQ_SCHED_RR_EN defined: round-robin arbitration.
  - A last-served pointer (reset 0) is updated to vec on ack.
  - Search starts at pointer+1 and wraps modulo CIrqCnt.
- Undefined: fixed priority as above; no pointer register.

Test Plan:
- Reset mid-REQ (pending=0x0004, AIrqReq=1), assert AResetHN=0 → AIrqReq=0, PEND reads 0x0000, STAT state=IDLE immediately.
- Pulse AIrqI[5] at cycle n → PEND=0x0020 at n+1, AIrqReq=1 and vec=5 at n+2. Ack → PEND=0, SERV. Eoi → IDLE.
- Raise AIrqI[3] and AIrqI[9] together → vec=3 first; after eoi, vec=9. With IRQ_SCHED_RR_EN and pointer=3, both re-raised → vec=9 then 3.
- Write 0x0100 to base+2 → PEND=0x0100, request with vec=8. Write 0x0100 to base+0 in SERV → PEND=0, state unaffected.
- Byte write to base+0 → AIoAddrErr=1, AIoAddrAck=0, PEND unchanged. Word read at base+4 → neither flag, AIoMiso=0.
- Same-cycle W1C of bit 2 and rising edge on AIrqI[2] → PEND bit 2 = 1. AClkHEn=0 while AIrqI rises and falls → no pending set.
